shift_xfer_ctrl: RTL
====================

# shift_xfer_ctrl

Sequencing controller that sits directly upstream of the team's N-bit universal shift register, driving its `ctrl`/`d` inputs and reading back its `q`. It accepts a parallel word and direction through a valid/ready request port. It then loads the register and performs exactly N shifts, presenting the outgoing serial bit on `sout` while shifting `sin` in. Finally it returns the captured word on a valid/ready response port, giving a full-duplex, SPI-style exchange.

## Interface
- `N`, default 8: word width. Must match the attached shift register. N ≥ 2.
- `clk`, input, 1: clock.
- `reset`, input, 1: asynchronous, active-high.
- `req_valid`, input, 1: request word present.
- `req_ready`, output, 1: controller can accept a request.
- `req_data`, input, N: word to transmit.
- `req_dir`, input, 1: 0 = shift left (MSB out first, `sin` enters LSB); 1 = shift right (LSB out first, `sin` enters MSB).
- `sin`, input, 1: serial input bit. Synchronous to `clk`.
- `sout`, output, 1: serial output bit.
- `ctrl`, output, 2: shift register control. 00 = hold, 01 = shift left, 10 = shift right, 11 = load.
- `d`, output, N: shift register data input.
- `q`, input, N: shift register contents.
- `rsp_valid`, output, 1: captured word available.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_data`, output, N: captured word.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States are IDLE, LOAD, SHIFT and DONE.
- **IDLE**
  - Outputs: `req_ready`=1, `ctrl`=00, `d`=0.
  - On `req_valid`&&`req_ready`, latch `req_data` and `req_dir`, then go to LOAD.
- **LOAD** (one cycle)
  - Outputs: `ctrl`=11, `d`=latched word. The register loads at the next edge.
  - Clear the bit counter, then go to SHIFT.
- **SHIFT** (exactly N cycles)
  - Left: `ctrl`=01, `d[0]`=`sin`, all other `d` bits 0.
  - Right: `ctrl`=10, `d[N-1]`=`sin`, all other `d` bits 0.
  - The counter increments each cycle. On the cycle where count = N-1, go to DONE.
- **DONE**
  - Outputs: `ctrl`=00 (register holds), `rsp_valid`=1, `rsp_data`=`q`.
  - On `rsp_ready`, go to IDLE.
- `sout`: combinational. `q[N-1]` when the latched direction is left, `q[0]` when right. It is meaningful only in SHIFT.
- The bit counter is $clog2(N+1) bits wide and never wraps during a transfer.
- The latched direction holds from acceptance until the return to IDLE. `req_*` inputs are ignored whenever `busy`=1.
- Simultaneous events:
  - `req_valid` arriving during DONE is not accepted. `req_ready`=0 in DONE.
  - A new request is taken no earlier than the cycle after the response handshake.
- Reset mid-operation: the controller returns to IDLE and the partial transfer is discarded. No `rsp_valid` is issued.

## Timing
- Reset values:
  - State IDLE, counter 0, latched word 0, latched direction 0.
  - Outputs: `req_ready`=1, `ctrl`=00, `d`=0, `rsp_valid`=0, `rsp_data`=`q` (0 while the register is in reset), `busy`=0, `sout`=`q[N-1]`.
- Edge numbering, with acceptance at edge E0:
  - LOAD occupies the cycle after E0. The register loads at E1.
  - Shifts happen at E2 through E(N+1).
  - `rsp_valid` rises after E(N+1), i.e. N+1 edges after acceptance.
- `sout` bit k (k = 0..N-1) is valid during the k-th SHIFT cycle. `sin` is sampled by the register at the end of that same cycle.
- With `rsp_ready` tied high, back-to-back transfers have a period of N+3 cycles.
- While `rsp_ready`=0, `rsp_valid` and `rsp_data` remain stable, and `ctrl` stays at 00.

## Structure
- Shared package `shift_pkg` holds:
  - Control constants `CTRL_HOLD`=2'b00, `CTRL_SHL`=2'b01, `CTRL_SHR`=2'b10, `CTRL_LOAD`=2'b11.
  - The state enum `xfer_state_t` (IDLE, LOAD, SHIFT, DONE).
  - The direction constants `DIR_LEFT`=0 and `DIR_RIGHT`=1.
- No sub-module. The shift register is instantiated beside this block in the parent, with `ctrl`/`d`/`q` wired point to point.
- The bench instantiates both blocks together.

## Test plan
All scenarios use N=8.
- **Reset:** assert `reset` for 2 cycles. Required: `req_ready`=1, `busy`=0, `ctrl`=00, `rsp_valid`=0, `q`=8'h00.
- **Left exchange:** `req_data`=8'hA5, `req_dir`=0, `sin` = 1,0,1,1,0,0,1,0.
  - `ctrl` = 11 once, then 01 eight times.
  - `sout` = 1,0,1,0,0,1,0,1.
  - `rsp_valid` 9 edges after acceptance, with `rsp_data`=8'hB2.
- **Right exchange:** `req_data`=8'h01, `req_dir`=1, `sin`=1 throughout.
  - `ctrl` = 11, then 10 eight times.
  - `sout` = 1,0,0,0,0,0,0,0.
  - `rsp_data`=8'hFF.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles in DONE.
  - `rsp_valid`=1 and `rsp_data` stay stable; `ctrl`=00; `req_ready`=0.
  - A `req_valid` pulse during this window is ignored.
  - After `rsp_ready`=1, the controller returns to IDLE.
- **Reset mid-shift:** assert `reset` after 3 shifts of 8'hFF.
  - Controller returns to IDLE; no response is issued.
  - A following transfer of 8'h3C with `sin`=0 returns `rsp_data`=8'h00 and `sout`=0,0,1,1,1,1,0,0.
- **Back-to-back:** `req_valid` and `rsp_ready` held high for 3 words.
  - Acceptances are N+3=11 cycles apart.
  - Each response matches its word, checked against a reference model.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register and its transfer controller.
package shift_pkg;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHL  = 2'b01;
    localparam logic [1:0] CTRL_SHR  = 2'b10;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

    // Register control code for one shift step in the given direction.
    function automatic logic [1:0] shift_ctrl(input logic dir);
        return (dir == DIR_RIGHT) ? CTRL_SHR : CTRL_SHL;
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// N-bit universal shift register: hold, shift left (d[0] in), shift right (d[N-1] in), load.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ctrl,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            case (ctrl)
                CTRL_SHL:  q <= {q[N-2:0], d[0]};
                CTRL_SHR:  q <= {d[N-1], q[N-1:1]};
                CTRL_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Sequences one full-duplex N-bit exchange through an attached universal shift register:
// load the request word, shift N times (sout out, sin in), then hand back the captured word.
module shift_xfer_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_data,
    input  logic         req_dir,
    input  logic         sin,
    output logic         sout,
    output logic [1:0]   ctrl,
    output logic [N-1:0] d,
    input  logic [N-1:0] q,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    xfer_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [N-1:0]     word, word_next;
    logic             dir, dir_next;

    // State, bit counter and latched request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            dir   <= DIR_LEFT;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            word  <= word_next;
            dir   <= dir_next;
        end
    end

    // Next state and register control; d must follow sin in the same cycle it is shifted in.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        word_next  = word;
        dir_next   = dir;
        req_ready  = 1'b0;
        ctrl       = CTRL_HOLD;
        d          = '0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    word_next  = req_data;
                    dir_next   = req_dir;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ctrl       = CTRL_LOAD;
                d          = word;
                cnt_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                ctrl = shift_ctrl(dir);
                if (dir == DIR_RIGHT) begin
                    d[N-1] = sin;
                end else begin
                    d[0] = sin;
                end
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rsp_data = q;
    assign sout     = (dir == DIR_RIGHT) ? q[0] : q[N-1];

endmodule
